// File: rtl/ld_st_queue_unit.sv
// rtl/ld_st_queue_unit.sv - MMIX load/store unit with store queue, forwarding and memory arbiter
//
// Stores retire one cycle after acceptance into a DEPTH-entry store queue that
// drains to the single-port memory in the background. Loads are checked against
// every queued store in the same octa: an exact (address, size) match on the
// youngest such store forwards its data, any other overlap waits for the drain,
// and no overlap lets the load go to memory ahead of the queue.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake (req_ready combinational)
//   req_is_store, req_size, req_signed, req_addr, req_wdata   request fields
//   st_done, st_ovf                   store retired pulse and its overflow flag
//   ld_done, ld_data                  load complete pulse and extended result
//   flush_req, flush_done             drain request level and completion pulse
//   sq_count                          number of queued stores
//   mem_*                             single-port memory strobe/done interface
module ld_st_queue_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_is_store,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [AW-1:0]           req_addr,
  input  logic [63:0]             req_wdata,
  output logic                    st_done,
  output logic                    st_ovf,
  output logic                    ld_done,
  output logic [63:0]             ld_data,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic [$clog2(DEPTH):0]  sq_count,
  output logic [AW-1:0]           mem_address,
  output logic [1:0]              mem_datasize,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [63:0]             mem_writedata,
  input  logic [63:0]             mem_readdata,
  input  logic                    mem_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_DRAIN} mstate_t;

  function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] a, input logic [1:0] s);
    logic [AW-1:0] m;
    m = a;
    case (s)
      2'd1:    m[0]   = 1'b0;
      2'd2:    m[1:0] = 2'b0;
      2'd3:    m[2:0] = 3'b0;
      default: m      = a;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] trunc_data(input logic [63:0] d, input logic [1:0] s);
    case (s)
      2'd0:    return {56'b0, d[7:0]};
      2'd1:    return {48'b0, d[15:0]};
      2'd2:    return {32'b0, d[31:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [63:0] extend_data(input logic [63:0] d, input logic [1:0] s, input logic sg);
    case (s)
      2'd0:    return {{56{sg & d[7]}}, d[7:0]};
      2'd1:    return {{48{sg & d[15]}}, d[15:0]};
      2'd2:    return {{32{sg & d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic data_ovf(input logic [63:0] d, input logic [1:0] s);
    case (s)
      2'd0:    return d[63:8]  != {56{d[7]}};
      2'd1:    return d[63:16] != {48{d[15]}};
      2'd2:    return d[63:32] != {32{d[31]}};
      default: return 1'b0;
    endcase
  endfunction

  logic [AW-1:0] q_addr [DEPTH];
  logic [1:0]    q_size [DEPTH];
  logic [63:0]   q_data [DEPTH];
  logic [PW-1:0] head, tail;

  mstate_t       state, state_nx;
  logic          ld_pend, ld_signed, flush_fired;
  logic [AW-1:0] ld_addr;
  logic [1:0]    ld_size;

  logic [AW-1:0] req_addr_al, cur_addr;
  logic [1:0]    cur_size;
  logic          cur_signed;
  logic          hit, exact, ld_check, ld_go, fwd_now;
  logic          st_acc, ld_acc, push, pop, flush_cond;
  logic [PW-1:0] hit_idx;

  assign req_addr_al = align_addr(req_addr, req_size);
  assign req_ready   = reset_n && !flush_req &&
                       (req_is_store ? (sq_count < CW'(DEPTH)) : !ld_pend);
  assign st_acc      = req_valid && req_ready && req_is_store;
  assign ld_acc      = req_valid && req_ready && !req_is_store;

  // A load is either being accepted now or pending; never both.
  assign cur_addr   = ld_pend ? ld_addr   : req_addr_al;
  assign cur_size   = ld_pend ? ld_size   : req_size;
  assign cur_signed = ld_pend ? ld_signed : req_signed;

  // Scan oldest to youngest so the last hit is the youngest same-octa store.
  always_comb begin
    logic [PW-1:0] idx;
    hit     = 1'b0;
    hit_idx = head;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < sq_count && q_addr[idx][AW-1:3] == cur_addr[AW-1:3]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign exact    = hit && q_addr[hit_idx] == cur_addr && q_size[hit_idx] == cur_size;
  // Once issued (M_LOAD) the load is ordered before any later store; stop checking.
  assign ld_check = ld_pend && state != M_LOAD;
  assign ld_go    = ld_check && !hit;
  assign fwd_now  = (ld_acc || ld_check) && exact;
  assign push     = st_acc;
  assign pop      = state == M_DRAIN && mem_done;
  assign flush_cond = flush_req && !flush_fired && sq_count == '0 && !ld_pend && state == M_IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= M_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      M_IDLE: begin
        if (ld_go)                state_nx = M_LOAD;
        else if (sq_count != '0)  state_nx = M_DRAIN;
      end
      M_LOAD:  if (mem_done) state_nx = M_IDLE;
      M_DRAIN: if (mem_done) state_nx = M_IDLE;
      default: state_nx = M_IDLE;
    endcase
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_datasize  = 2'd0;
    mem_writedata = 64'd0;
    case (state)
      M_LOAD: begin
        mem_read     = 1'b1;
        mem_address  = ld_addr;
        mem_datasize = ld_size;
      end
      M_DRAIN: begin
        mem_write     = 1'b1;
        mem_address   = q_addr[head];
        mem_datasize  = q_size[head];
        mem_writedata = q_data[head];
      end
      default: ;
    endcase
  end

  // Queue payload needs no reset; validity comes from head/sq_count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= req_addr_al;
      q_size[tail] <= req_size;
      q_data[tail] <= trunc_data(req_wdata, req_size);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      sq_count    <= '0;
      st_done     <= 1'b0;
      st_ovf      <= 1'b0;
      ld_done     <= 1'b0;
      ld_data     <= 64'd0;
      ld_pend     <= 1'b0;
      ld_addr     <= '0;
      ld_size     <= 2'd0;
      ld_signed   <= 1'b0;
      flush_done  <= 1'b0;
      flush_fired <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   sq_count <= sq_count + CW'(1);
        2'b01:   sq_count <= sq_count - CW'(1);
        default: ;
      endcase

      st_done <= st_acc;
      st_ovf  <= st_acc && req_signed && data_ovf(req_wdata, req_size);

      ld_done <= fwd_now || (state == M_LOAD && mem_done);
      if (fwd_now)
        ld_data <= extend_data(q_data[hit_idx], cur_size, cur_signed);
      else if (state == M_LOAD && mem_done)
        ld_data <= extend_data(mem_readdata, ld_size, ld_signed);

      if (ld_acc && !exact) begin
        ld_pend   <= 1'b1;
        ld_addr   <= req_addr_al;
        ld_size   <= req_size;
        ld_signed <= req_signed;
      end else if ((ld_check && exact) || (state == M_LOAD && mem_done)) begin
        ld_pend <= 1'b0;
      end

      flush_done  <= flush_cond;
      flush_fired <= flush_req && (flush_fired || flush_cond);
    end
  end

endmodule

// File: tb/tb_ld_st_queue_unit.sv
// tb/tb_ld_st_queue_unit.sv - directed self-checking bench for ld_st_queue_unit
module tb_ld_st_queue_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        st_done, st_ovf, ld_done, flush_done;
  logic [63:0] ld_data;
  logic        flush_req = 1'b0;
  logic [2:0]  sq_count;
  logic [63:0] mem_address, mem_writedata;
  logic [1:0]  mem_datasize;
  logic        mem_read, mem_write;
  logic [63:0] mem_readdata;
  logic        mem_done = 1'b0;

  int tests = 0;
  int fails = 0;

  // memory model state
  logic        mem_hold = 1'b0;
  int          mem_lat = 0;
  int          lat_cnt = 0;
  logic [63:0] rd_value = 64'd0;
  int          wr_count = 0, rd_count = 0, rd_seen = 0, rd_start_wr = -1;
  logic [63:0] wr_addr_log [16];
  logic [63:0] wr_data_log [16];
  logic [1:0]  wr_size_log [16];
  logic [63:0] rd_addr;
  logic [1:0]  rd_size;

  assign mem_readdata = rd_value;

  always #5 clk = ~clk;

  ld_st_queue_unit #(.DEPTH(4), .AW(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .st_done(st_done), .st_ovf(st_ovf), .ld_done(ld_done), .ld_data(ld_data),
    .flush_req(flush_req), .flush_done(flush_done), .sq_count(sq_count),
    .mem_address(mem_address), .mem_datasize(mem_datasize), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_done(mem_done)
  );

  // Memory responds on the falling edge; mem_done is seen at the next rising edge.
  always @(negedge clk) begin
    if (mem_read) rd_seen = rd_seen + 1;
    if (!reset_n || !(mem_read || mem_write)) begin
      mem_done = 1'b0;
      lat_cnt  = 0;
    end else if (mem_hold) begin
      mem_done = 1'b0;
    end else begin
      if (mem_read && lat_cnt == 0) rd_start_wr = wr_count;
      if (lat_cnt >= mem_lat) begin
        mem_done = 1'b1;
        lat_cnt  = 0;
        if (mem_write) begin
          if (wr_count < 16) begin
            wr_addr_log[wr_count] = mem_address;
            wr_data_log[wr_count] = mem_writedata;
            wr_size_log[wr_count] = mem_datasize;
          end
          wr_count = wr_count + 1;
        end else begin
          rd_count = rd_count + 1;
          rd_addr  = mem_address;
          rd_size  = mem_datasize;
        end
      end else begin
        mem_done = 1'b0;
        lat_cnt  = lat_cnt + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [63:0] a, input logic [1:0] s, input logic sg, input logic [63:0] d);
    int n;
    req_is_store = 1'b1; req_addr = a; req_size = s; req_signed = sg; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin tick; n++; end
    tick;
    req_valid = 1'b0;
  endtask

  task automatic offer_load(input logic [63:0] a, input logic [1:0] s, input logic sg);
    req_is_store = 1'b0; req_addr = a; req_size = s; req_signed = sg; req_valid = 1'b1;
  endtask

  task automatic wait_drained(output bit ok);
    int n;
    n = 0;
    while ((sq_count != 0 || mem_write || mem_read) && n < 200) begin tick; n++; end
    tick;
    ok = (sq_count == 0);
  endtask

  task automatic wait_ld_done(output bit ok);
    int n;
    n = 0;
    while (!ld_done && n < 100) begin tick; n++; end
    ok = ld_done;
  endtask

  task automatic test_reset;
    req_valid = 1'b1; req_is_store = 1'b1;
    #3;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    tests++; if (sq_count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", sq_count); end
    tests++; if ({st_done, st_ovf, ld_done, flush_done, mem_read, mem_write} !== 6'b0) begin
      fails++; $display("FAIL reset_strobes got=%b exp=000000", {st_done, st_ovf, ld_done, flush_done, mem_read, mem_write}); end
    tests++; if (ld_data !== 64'd0 || mem_address !== 64'd0) begin
      fails++; $display("FAIL reset_data got=%h/%h exp=0/0", ld_data, mem_address); end
    req_valid = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_forward;
    bit ok;
    mem_hold = 1'b0; mem_lat = 0; wr_count = 0; rd_seen = 0;
    do_store(64'h100, 2'd3, 1'b0, 64'h1122334455667788);
    tests++; if (st_done !== 1'b1 || sq_count !== 3'd1) begin
      fails++; $display("FAIL fwd_store got=st_done %b count %0d exp=1/1", st_done, sq_count); end
    offer_load(64'h100, 2'd3, 1'b0);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL fwd_ready got=%b exp=1", req_ready); end
    tick;
    req_valid = 1'b0;
    tests++; if (ld_done !== 1'b1 || ld_data !== 64'h1122334455667788) begin
      fails++; $display("FAIL fwd_octa got=%b %h exp=1 1122334455667788", ld_done, ld_data); end
    tests++; if (st_done !== 1'b0) begin fails++; $display("FAIL fwd_st_pulse got=%b exp=0", st_done); end
    wait_drained(ok);
    tests++; if (!ok || rd_seen != 0 || wr_count != 1 || wr_data_log[0] !== 64'h1122334455667788) begin
      fails++; $display("FAIL fwd_drain got=ok %0d rd_seen %0d wr %0d data %h exp=1 0 1 1122334455667788",
                        ok, rd_seen, wr_count, wr_data_log[0]); end
    do_store(64'h400, 2'd0, 1'b0, 64'h80);
    offer_load(64'h400, 2'd0, 1'b1);
    tick;
    req_valid = 1'b0;
    tests++; if (ld_done !== 1'b1 || ld_data !== 64'hFFFFFFFFFFFFFF80) begin
      fails++; $display("FAIL fwd_signed_byte got=%b %h exp=1 ffffffffffffff80", ld_done, ld_data); end
    wait_drained(ok);
    tests++; if (rd_seen != 0) begin fails++; $display("FAIL fwd_no_read got=%0d exp=0", rd_seen); end
  endtask

  task automatic test_hazard;
    bit ok;
    mem_hold = 1'b0; mem_lat = 2; wr_count = 0; rd_count = 0; rd_start_wr = -1;
    rd_value = 64'h5555555555555542;
    do_store(64'h103, 2'd0, 1'b0, 64'hFF);
    offer_load(64'h100, 2'd0, 1'b0);
    tick;
    req_valid = 1'b0;
    tests++; if (ld_done !== 1'b0) begin fails++; $display("FAIL haz_no_fwd got=%b exp=0", ld_done); end
    wait_ld_done(ok);
    tests++; if (!ok || ld_data !== 64'h42) begin
      fails++; $display("FAIL haz_ld_data got=%b %h exp=1 42", ok, ld_data); end
    tests++; if (wr_count != 1 || wr_addr_log[0] !== 64'h103 || wr_size_log[0] !== 2'd0 || wr_data_log[0] !== 64'hFF) begin
      fails++; $display("FAIL haz_write got=%0d %h %0d %h exp=1 103 0 ff",
                        wr_count, wr_addr_log[0], wr_size_log[0], wr_data_log[0]); end
    tests++; if (rd_start_wr != 1 || rd_count != 1 || rd_addr !== 64'h100 || rd_size !== 2'd0) begin
      fails++; $display("FAIL haz_read_order got=%0d %0d %h %0d exp=1 1 100 0",
                        rd_start_wr, rd_count, rd_addr, rd_size); end
    wait_drained(ok);
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    mem_hold = 1'b1; mem_lat = 0; wr_count = 0;
    req_is_store = 1'b1; req_size = 2'd3; req_signed = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 64'h200 + 64'(8 * i); req_wdata = 64'(i + 1);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got=%b exp=1", i, req_ready); end
      tick;
      tests++; if (st_done !== 1'b1) begin fails++; $display("FAIL b2b_st_done%0d got=%b exp=1", i, st_done); end
    end
    req_addr = 64'h220; req_wdata = 64'h5;
    for (int i = 0; i < 3; i++) begin
      tests++; if (req_ready !== 1'b0 || sq_count !== 3'd4) begin
        fails++; $display("FAIL b2b_full%0d got=%b %0d exp=0 4", i, req_ready, sq_count); end
      tick;
    end
    mem_hold = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin tick; n++; end
    tests++; if (req_ready !== 1'b1 || wr_count != 1) begin
      fails++; $display("FAIL b2b_release got=%b wr %0d exp=1 1", req_ready, wr_count); end
    tick;
    req_valid = 1'b0;
    tests++; if (st_done !== 1'b1) begin fails++; $display("FAIL b2b_fifth got=%b exp=1", st_done); end
    wait_drained(ok);
    tests++; if (!ok || wr_count != 5 || wr_addr_log[4] !== 64'h220 || wr_data_log[3] !== 64'h4) begin
      fails++; $display("FAIL b2b_order got=%0d %h %h exp=5 220 4", wr_count, wr_addr_log[4], wr_data_log[3]); end
  endtask

  task automatic test_overflow;
    bit ok;
    logic [63:0] v_addr [4] = '{64'h300, 64'h311, 64'h326, 64'h335};
    logic [1:0]  v_size [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic        v_sg   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] v_data [4] = '{64'h180, 64'hFFFFFFFFFFFF8000, 64'h80000000, 64'h180};
    logic        e_ovf  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] e_addr [4] = '{64'h300, 64'h310, 64'h324, 64'h335};
    logic [63:0] e_data [4] = '{64'h80, 64'h8000, 64'h80000000, 64'h80};
    mem_hold = 1'b0; mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      wr_count = 0;
      do_store(v_addr[i], v_size[i], v_sg[i], v_data[i]);
      tests++; if (st_done !== 1'b1 || st_ovf !== e_ovf[i]) begin
        fails++; $display("FAIL ovf%0d got=%b %b exp=1 %b", i, st_done, st_ovf, e_ovf[i]); end
      wait_drained(ok);
      tests++; if (wr_count != 1 || wr_addr_log[0] !== e_addr[i] || wr_data_log[0] !== e_data[i]) begin
        fails++; $display("FAIL ovf_write%0d got=%0d %h %h exp=1 %h %h",
                          i, wr_count, wr_addr_log[0], wr_data_log[0], e_addr[i], e_data[i]); end
    end
  endtask

  task automatic test_flush;
    int pulses, pulse_wr, ready_seen;
    mem_hold = 1'b1; mem_lat = 1; wr_count = 0;
    do_store(64'h500, 2'd3, 1'b0, 64'h1);
    do_store(64'h508, 2'd3, 1'b0, 64'h2);
    do_store(64'h510, 2'd3, 1'b0, 64'h3);
    flush_req = 1'b1;
    offer_load(64'h600, 2'd3, 1'b0);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_ld_ready got=%b exp=0", req_ready); end
    mem_hold = 1'b0;
    pulses = 0; pulse_wr = -1; ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (req_ready) ready_seen++;
      if (flush_done) begin
        pulses++;
        if (pulse_wr < 0) pulse_wr = wr_count;
      end
    end
    tests++; if (pulses != 1 || pulse_wr != 3 || sq_count !== 3'd0 || ready_seen != 0) begin
      fails++; $display("FAIL flush_drain got=pulses %0d wr %0d count %0d ready %0d exp=1 3 0 0",
                        pulses, pulse_wr, sq_count, ready_seen); end
    req_valid = 1'b0; flush_req = 1'b0;
    tick; tick;
    flush_req = 1'b1;
    tick;
    tests++; if (flush_done !== 1'b1) begin fails++; $display("FAIL flush_empty got=%b exp=1", flush_done); end
    tick;
    tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL flush_once got=%b exp=0", flush_done); end
    flush_req = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_drain;
    bit ok;
    mem_hold = 1'b1; mem_lat = 0;
    do_store(64'h100, 2'd3, 1'b0, 64'hAAAA);
    tick;
    tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL rst_pre_write got=%b exp=1", mem_write); end
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if (mem_write !== 1'b0 || sq_count !== 3'd0) begin
      fails++; $display("FAIL rst_async got=%b %0d exp=0 0", mem_write, sq_count); end
    tick;
    reset_n = 1'b1; mem_hold = 1'b0; rd_count = 0; rd_seen = 0;
    rd_value = 64'h0123456789ABCDEF;
    offer_load(64'h100, 2'd3, 1'b0);
    tick;
    req_valid = 1'b0;
    tests++; if (ld_done !== 1'b0) begin fails++; $display("FAIL rst_no_fwd got=%b exp=0", ld_done); end
    wait_ld_done(ok);
    tests++; if (!ok || rd_count != 1 || ld_data !== 64'h0123456789ABCDEF) begin
      fails++; $display("FAIL rst_load got=%b %0d %h exp=1 1 0123456789abcdef", ok, rd_count, ld_data); end
    wait_drained(ok);
  endtask

  initial begin
    test_reset;
    test_forward;
    test_hazard;
    test_back_to_back;
    test_overflow;
    test_flush;
    test_reset_mid_drain;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
